// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
//
// Buttons are debounced upstream, and each press arrives here as a one-clock
// pulse. This block keeps one pending flag per button. A round-robin arbiter
// moves at most one pending press per clock into a small event FIFO. The FIFO
// head goes to a single consumer over a valid/ready handshake.
//
// Parameters
//   NUM_BTN     number of button pulse inputs (>= 2)
//   FIFO_DEPTH  event FIFO entries (power of 2, >= 2)
//   IDW         width of an event ID (button index)
//   CW          width of the FIFO occupancy count (0..FIFO_DEPTH)
//
// Ports
//   i_clk         system clock, all logic on the rising edge
//   i_rst_n       asynchronous active-low reset, drops all pending/queued events
//   i_btn_pulse   one-clock press pulses, bit k = button k
//   o_evt_valid   FIFO head holds an event
//   o_evt_id      button index at the FIFO head (meaningless while not valid)
//   i_evt_ready   consumer accepts the head when o_evt_valid is high
//   o_pending     registered per-button pending flags
//   o_fifo_count  FIFO occupancy
//   o_overflow    sticky flag, set when a press is lost
//   i_clr_ovf     one-clock pulse that clears o_overflow (a new loss wins)
// -----------------------------------------------------------------------------
module btn_event_arbiter #(
  parameter int NUM_BTN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NUM_BTN),
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] i_btn_pulse,
  output logic               o_evt_valid,
  output logic [IDW-1:0]     o_evt_id,
  input  logic               i_evt_ready,
  output logic [NUM_BTN-1:0] o_pending,
  output logic [CW-1:0]      o_fifo_count,
  output logic               o_overflow,
  input  logic               i_clr_ovf
);

  localparam int             PW        = $clog2(FIFO_DEPTH);
  localparam logic [IDW:0]   NUM_BTN_W = (IDW+1)'(NUM_BTN);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_BTN - 1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] pend_reg,   pend_next;
  logic [IDW-1:0]     rr_reg,     rr_next;
  logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg,  count_next;
  logic               ovf_reg,    ovf_next;

  // The FIFO storage has no reset. Occupancy and the pointers decide what
  // is valid, so stale contents after a reset are never presented as valid.
  logic [IDW-1:0]     mem_reg [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic pop;
  logic push;
  logic can_push;

  assign o_evt_valid = (count_reg != '0);
  assign o_evt_id    = mem_reg[rd_ptr_reg];
  assign pop         = o_evt_valid && i_evt_ready;
  // A pop in the same clock frees a slot, so a full FIFO can still take
  // a grant while the consumer drains it.
  assign can_push    = (count_reg != DEPTH_C) || pop;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  //
  // Candidate slot gi is button (rr + gi) mod NUM_BTN. The first pending
  // candidate in slot order is granted. Both operands are below NUM_BTN, so
  // one conditional subtract is enough for the wrap.
  // ---------------------------------------------------------------------------
  logic [IDW:0]       cand_sum  [NUM_BTN];
  logic [IDW-1:0]     cand_idx  [NUM_BTN];
  logic [NUM_BTN-1:0] cand_pend;
  logic               grant_any;
  logic [IDW-1:0]     grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_cand
      assign cand_sum[gi]  = {1'b0, rr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi]  = (cand_sum[gi] >= NUM_BTN_W)
                             ? IDW'(cand_sum[gi] - NUM_BTN_W)
                             : cand_sum[gi][IDW-1:0];
      assign cand_pend[gi] = pend_reg[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest pending slot to rr is assigned last
  // and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (cand_pend[i]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  // A grant only issues when the FIFO can accept it. Otherwise the
  // pending flag holds and the press waits.
  assign push = grant_any && can_push;

  always_comb begin
    rr_next = rr_reg;
    if (push) begin
      rr_next = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending flags and lost-press detection
  //
  // A pulse always leaves the flag set. If the button is granted in that same
  // clock, the old press leaves with the grant and the new press takes its
  // place. If the button is already pending and not granted, the second press
  // has nowhere to go and is counted as lost.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] granted_vec;
  logic [NUM_BTN-1:0] drop_vec;

  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_pend
      assign granted_vec[gi] = push && (grant_idx == IDW'(gi));
      assign pend_next[gi]   = i_btn_pulse[gi] ? 1'b1
                             : (granted_vec[gi] ? 1'b0 : pend_reg[gi]);
      assign drop_vec[gi]    = i_btn_pulse[gi] && pend_reg[gi] && !granted_vec[gi];
    end
  endgenerate

  // A new loss beats a clear in the same clock, so no loss goes unreported.
  always_comb begin
    ovf_next = ovf_reg;
    if (|drop_vec) begin
      ovf_next = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    // A push and a pop together leave the count unchanged, which keeps a
    // full FIFO full while it streams.
    count_next = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_reg   <= '0;
      rr_reg     <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      rr_reg     <= rr_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign o_pending    = pend_reg;
  assign o_fifo_count = count_reg;
  assign o_overflow   = ovf_reg;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_btn_event_arbiter
//
// Test structure:
//   * Directed table of {inputs, expected outputs} rows, one clock per row.
//   * A hand-written sequence for the asynchronous reset case.
//   * Randomized traffic checked against a queue-based reference model.
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge that follows each rising edge.
// -----------------------------------------------------------------------------
module tb_btn_event_arbiter;

  localparam int NB    = 4;
  localparam int DEPTH = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [NB-1:0] i_btn_pulse;
  logic          o_evt_valid;
  logic [1:0]    o_evt_id;
  logic          i_evt_ready;
  logic [NB-1:0] o_pending;
  logic [2:0]    o_fifo_count;
  logic          o_overflow;
  logic          i_clr_ovf;

  btn_event_arbiter #(
    .NUM_BTN    (NB),
    .FIFO_DEPTH (DEPTH),
    .IDW        (2),
    .CW         (3)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_btn_pulse  (i_btn_pulse),
    .o_evt_valid  (o_evt_valid),
    .o_evt_id     (o_evt_id),
    .i_evt_ready  (i_evt_ready),
    .o_pending    (o_pending),
    .o_fifo_count (o_fifo_count),
    .o_overflow   (o_overflow),
    .i_clr_ovf    (i_clr_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [1:0] eid,
                               input logic [3:0] epend, input logic [2:0] ecnt, input logic eovf);
    chk({tag, " valid"}, 32'(o_evt_valid), 32'(ev));
    if (ev) chk({tag, " id"}, 32'(o_evt_id), 32'(eid));
    chk({tag, " pending"},  32'(o_pending),    32'(epend));
    chk({tag, " count"},    32'(o_fifo_count), 32'(ecnt));
    chk({tag, " overflow"}, 32'(o_overflow),   32'(eovf));
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending set, round-robin start, and an event queue.
  // ---------------------------------------------------------------------------
  bit m_pend [NB];
  int m_rr;
  int m_q [$];
  bit m_ovf;

  function automatic void model_reset();
    for (int k = 0; k < NB; k++) m_pend[k] = 1'b0;
    m_rr  = 0;
    m_q   = {};
    m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input logic rst, input logic [NB-1:0] pulse,
                                     input logic ready, input logic clr);
    bit pop_m;
    bit push_m;
    bit lost;
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    pop_m = (m_q.size() > 0) && ready;
    g = -1;
    for (int off = 0; off < NB; off++) begin
      if (g < 0 && m_pend[(m_rr + off) % NB]) g = (m_rr + off) % NB;
    end
    push_m = (g >= 0) && ((m_q.size() < DEPTH) || pop_m);
    if (pop_m) void'(m_q.pop_front());
    if (push_m) begin
      m_q.push_back(g);
      m_rr = (g + 1) % NB;
    end
    lost = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (pulse[k]) begin
        if (m_pend[k] && !(push_m && g == k)) lost = 1'b1;
        m_pend[k] = 1'b1;
      end else if (push_m && g == k) begin
        m_pend[k] = 1'b0;
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  // One clock: drive on the falling edge, advance the model at the rising
  // edge, and return on the next falling edge ready to sample.
  task automatic step(input logic rst, input logic [NB-1:0] pulse,
                      input logic ready, input logic clr);
    i_rst_n     = !rst;
    i_btn_pulse = pulse;
    i_evt_ready = ready;
    i_clr_ovf   = clr;
    @(posedge i_clk);
    model_step(rst, pulse, ready, clr);
    @(negedge i_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [3:0] pulse;
    logic       ready;
    logic       clr;
    logic       e_valid;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [2:0] e_count;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic rst, input logic [3:0] pulse, input logic ready, input logic clr,
                     input logic ev, input logic [1:0] eid, input logic [3:0] epend,
                     input logic [2:0] ecnt, input logic eovf);
    vec_t v;
    v.rst = rst; v.pulse = pulse; v.ready = ready; v.clr = clr;
    v.e_valid = ev; v.e_id = eid; v.e_pend = epend; v.e_count = ecnt; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    // Single press on btn2: event valid two clocks after the pulse, then popped.
    add(0, 4'b0100, 0, 0,  0, 0, 4'b0100, 0, 0);
    add(0, 4'b0000, 0, 0,  1, 2, 4'b0000, 1, 0);
    add(0, 4'b0000, 1, 0,  0, 0, 4'b0000, 0, 0);
    // All four buttons at once after reset: queued in order 0,1,2,3.
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 0,  0, 0, 4'b1111, 0, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b1110, 1, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b1100, 2, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b1000, 3, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b0000, 4, 0);
    // Full FIFO: btn1 waits as pending; one pop lets it in, count stays 4.
    add(0, 4'b0010, 0, 0,  1, 0, 4'b0010, 4, 0);
    add(0, 4'b0000, 0, 0,  1, 0, 4'b0010, 4, 0);
    add(0, 4'b0000, 1, 0,  1, 1, 4'b0000, 4, 0);
    // btn1 blocked, second press lost; clear; clear with a coincident loss.
    add(0, 4'b0010, 0, 0,  1, 1, 4'b0010, 4, 0);
    add(0, 4'b0010, 0, 0,  1, 1, 4'b0010, 4, 1);
    add(0, 4'b0000, 0, 1,  1, 1, 4'b0010, 4, 0);
    add(0, 4'b0010, 0, 1,  1, 1, 4'b0010, 4, 1);
    add(0, 4'b0000, 0, 1,  1, 1, 4'b0010, 4, 0);
    // Drain: queue holds 1,2,3,1 and the pending btn1 enters on the first pop.
    add(0, 4'b0000, 1, 0,  1, 2, 4'b0000, 4, 0);
    add(0, 4'b0000, 1, 0,  1, 3, 4'b0000, 3, 0);
    add(0, 4'b0000, 1, 0,  1, 1, 4'b0000, 2, 0);
    add(0, 4'b0000, 1, 0,  1, 1, 4'b0000, 1, 0);
    add(0, 4'b0000, 1, 0,  0, 0, 4'b0000, 0, 0);
    // rr=2 after granting btn1: btn0 and btn3 pending -> btn3 first, then btn0.
    add(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);
    add(0, 4'b0010, 0, 0,  0, 0, 4'b0010, 0, 0);
    add(0, 4'b0000, 0, 0,  1, 1, 4'b0000, 1, 0);
    add(0, 4'b1001, 1, 0,  0, 0, 4'b1001, 0, 0);
    add(0, 4'b0000, 0, 0,  1, 3, 4'b0001, 1, 0);
    add(0, 4'b0000, 0, 0,  1, 3, 4'b0000, 2, 0);
    add(0, 4'b0000, 1, 0,  1, 0, 4'b0000, 1, 0);
    add(0, 4'b0000, 1, 0,  0, 0, 4'b0000, 0, 0);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n     = 1'b0;
    i_btn_pulse = '0;
    i_evt_ready = 1'b0;
    i_clr_ovf   = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_outputs("reset", 0, 0, 4'b0000, 0, 0);

    // Directed table
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].pulse, vecs[i].ready, vecs[i].clr);
      $display("vec %0d: pulse=%b ready=%b clr=%b -> valid=%b id=%0d pend=%b cnt=%0d ovf=%b",
               i, vecs[i].pulse, vecs[i].ready, vecs[i].clr,
               o_evt_valid, o_evt_id, o_pending, o_fifo_count, o_overflow);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_id,
                    vecs[i].e_pend, vecs[i].e_count, vecs[i].e_ovf);
    end

    // Asynchronous reset with three queued and two pending events
    step(0, 4'b0111, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0011, 0, 0);
    check_outputs("prerst", 1, 1, 4'b0011, 3, 0);
    i_btn_pulse = '0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("asyncrst valid",   32'(o_evt_valid),  32'd0);
    chk("asyncrst pending", 32'(o_pending),    32'd0);
    chk("asyncrst count",   32'(o_fifo_count), 32'd0);
    chk("asyncrst ovf",     32'(o_overflow),   32'd0);
    $display("async reset: valid=%b pend=%b cnt=%0d ovf=%b",
             o_evt_valid, o_pending, o_fifo_count, o_overflow);
    model_reset();
    @(negedge i_clk);
    step(0, 4'b0001, 0, 0);
    step(0, 4'b0000, 0, 0);
    check_outputs("postrst", 1, 0, 4'b0000, 1, 0);
    $display("post reset: valid=%b id=%0d cnt=%0d", o_evt_valid, o_evt_id, o_fifo_count);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [NB-1:0] p;
      logic          rdy;
      logic          clr;
      logic          rst;
      for (int k = 0; k < NB; k++) p[k] = ($urandom_range(3) == 0);
      // Alternate stretches of slow and fast consumer so the FIFO both fills and drains.
      rdy = ((n / 200) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      clr = ($urandom_range(15) == 0);
      rst = ($urandom_range(499) == 0);
      step(rst, p, rdy, clr);
      chk("rand valid", 32'(o_evt_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("rand id", 32'(o_evt_id), 32'(m_q[0]));
      chk("rand pending", 32'(o_pending),
          32'({m_pend[3], m_pend[2], m_pend[1], m_pend[0]}));
      chk("rand count", 32'(o_fifo_count), 32'(m_q.size()));
      chk("rand overflow", 32'(o_overflow), 32'(m_ovf));
      if (n % 100 == 0) begin
        $display("rand %0d: pulse=%b ready=%b -> valid=%b cnt=%0d pend=%b ovf=%b",
                 n, p, rdy, o_evt_valid, o_fifo_count, o_pending, o_overflow);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
